// File: rtl/ber_monitor.sv
// ber_monitor: 16-QAM slicer + PRBS-9 lock detector and bit error counter.
// Optional BER_ERR_INJECT_EN adds inject_err, which inverts received b0.
module ber_monitor #(
    parameter logic signed [11:0] SLICE_THR   = 12'sd512,
    parameter int unsigned        VERIFY_SYMS = 16,
    parameter int unsigned        WINDOW_SYMS = 1024,
    parameter int unsigned        LOSS_THR    = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [11:0] sym_I,
    input  logic signed [11:0] sym_Q,
    input  logic               sym_valid,
    input  logic               clear,
`ifdef BER_ERR_INJECT_EN
    input  logic               inject_err,
`endif
    output logic               locked,
    output logic [1:0]         state,
    output logic [31:0]        err_total,
    output logic [31:0]        bit_total,
    output logic [15:0]        win_errors,
    output logic               win_done
);

    localparam int VW = $clog2(VERIFY_SYMS + 1);
    localparam int WW = $clog2(WINDOW_SYMS + 1);
    localparam logic [VW-1:0] VERIFY_LAST = VW'(VERIFY_SYMS - 1);
    localparam logic [WW-1:0] WIN_LAST    = WW'(WINDOW_SYMS - 1);
    localparam logic [31:0]   LOSS_LIM    = LOSS_THR;

    typedef enum logic [1:0] {
        SEARCH = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10
    } state_e;

    state_e        state_q;
    logic          locked_q;
    // Only the 5 newest bits of earlier symbols are needed to seed the LFSR.
    logic [4:0]    hist_q;
    logic [1:0]    hcnt_q;
    logic [8:0]    lfsr_q;
    logic [VW-1:0] vcnt_q;
    logic [WW-1:0] win_cnt_q;
    logic [15:0]   win_sum_q;
    logic [31:0]   err_total_q;
    logic [31:0]   bit_total_q;
    logic [15:0]   win_errors_q;
    logic          win_done_q;

    logic [3:0]    rx;
    logic [3:0]    pred;
    logic [3:0]    miss;
    logic [8:0]    lfsr_adv;
    logic [2:0]    nerr;
    logic [32:0]   err_sum;
    logic [32:0]   bit_sum;
    logic [16:0]   win_sum_x;
    logic [31:0]   err_total_d;
    logic [31:0]   bit_total_d;
    logic [15:0]   win_sum_d;
    logic          win_end;
    logic          loss;

    function automatic logic [1:0] slice(input logic signed [11:0] v);
        if (v < -SLICE_THR)
            return 2'b00;
        else if (v < 12'sd0)
            return 2'b01;
        else if (v < SLICE_THR)
            return 2'b11;
        else
            return 2'b10;
    endfunction

    // Slice, predict next 4 PRBS bits, count errors and form saturating sums.
    always_comb begin
        rx = {slice(sym_I), slice(sym_Q)};
`ifdef BER_ERR_INJECT_EN
        rx[0] = rx[0] ^ inject_err;
`endif
        pred = {lfsr_q[8] ^ lfsr_q[4], lfsr_q[7] ^ lfsr_q[3],
                lfsr_q[6] ^ lfsr_q[2], lfsr_q[5] ^ lfsr_q[1]};
        lfsr_adv = {lfsr_q[4:0], pred};
        miss = rx ^ pred;
        nerr = {2'b0, miss[3]} + {2'b0, miss[2]}
             + {2'b0, miss[1]} + {2'b0, miss[0]};
        err_sum = {1'b0, err_total_q} + {30'd0, nerr};
        bit_sum = {1'b0, bit_total_q} + 33'd4;
        win_sum_x = {1'b0, win_sum_q} + {14'd0, nerr};
        err_total_d = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
        bit_total_d = bit_sum[32] ? 32'hFFFF_FFFF : bit_sum[31:0];
        win_sum_d = win_sum_x[16] ? 16'hFFFF : win_sum_x[15:0];
        win_end = (win_cnt_q == WIN_LAST);
        loss = ({16'd0, win_sum_d} >= LOSS_LIM);
    end

    // Lock FSM, LFSR tracking and error/window counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= SEARCH;
            locked_q     <= 1'b0;
            hist_q       <= '0;
            hcnt_q       <= '0;
            lfsr_q       <= '0;
            vcnt_q       <= '0;
            win_cnt_q    <= '0;
            win_sum_q    <= '0;
            err_total_q  <= '0;
            bit_total_q  <= '0;
            win_errors_q <= '0;
            win_done_q   <= 1'b0;
        end else begin
            win_done_q <= 1'b0;
            if (sym_valid) begin
                unique case (state_q)
                    SEARCH: begin
                        hist_q <= {hist_q[0], rx};
                        if (hcnt_q == 2'd2) begin
                            lfsr_q  <= {hist_q, rx};
                            hcnt_q  <= '0;
                            vcnt_q  <= '0;
                            state_q <= VERIFY;
                        end else begin
                            hcnt_q <= hcnt_q + 2'd1;
                        end
                    end
                    VERIFY: begin
                        lfsr_q <= lfsr_adv;
                        if (miss != 4'b0) begin
                            state_q <= SEARCH;
                            hcnt_q  <= '0;
                        end else if (vcnt_q == VERIFY_LAST) begin
                            state_q   <= LOCKED;
                            locked_q  <= 1'b1;
                            win_cnt_q <= '0;
                            win_sum_q <= '0;
                        end else begin
                            vcnt_q <= vcnt_q + VW'(1);
                        end
                    end
                    LOCKED: begin
                        lfsr_q <= lfsr_adv;
                        if (!clear) begin
                            err_total_q <= err_total_d;
                            bit_total_q <= bit_total_d;
                            if (win_end) begin
                                win_errors_q <= win_sum_d;
                                win_done_q   <= 1'b1;
                                win_cnt_q    <= '0;
                                win_sum_q    <= '0;
                                if (loss) begin
                                    state_q  <= SEARCH;
                                    locked_q <= 1'b0;
                                    hcnt_q   <= '0;
                                end
                            end else begin
                                win_cnt_q <= win_cnt_q + WW'(1);
                                win_sum_q <= win_sum_d;
                            end
                        end
                    end
                    default: begin
                        state_q  <= SEARCH;
                        locked_q <= 1'b0;
                        hcnt_q   <= '0;
                    end
                endcase
            end
            if (clear) begin
                err_total_q  <= '0;
                bit_total_q  <= '0;
                win_errors_q <= '0;
                win_sum_q    <= '0;
                win_cnt_q    <= '0;
            end
        end
    end

    assign state      = state_q;
    assign locked     = locked_q;
    assign err_total  = err_total_q;
    assign bit_total  = bit_total_q;
    assign win_errors = win_errors_q;
    assign win_done   = win_done_q;

endmodule

// File: tb/tb_ber_monitor.sv
// tb_ber_monitor: directed bench for ber_monitor using a PRBS-9 16-QAM source.
// Errors are created by flipping transmitted bits; BER_ERR_INJECT_EN adds an inject case.
module tb_ber_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] sym_I;
    logic [11:0] sym_Q;
    logic        sym_valid;
    logic        clear;
`ifdef BER_ERR_INJECT_EN
    logic        inject_err;
`endif
    logic        locked;
    logic [1:0]  state;
    logic [31:0] err_total;
    logic [31:0] bit_total;
    logic [15:0] win_errors;
    logic        win_done;

    int n_cmp  = 0;
    int n_fail = 0;
    int wd_cnt = 0;
    int wd0;
    int alt    = 0;
    bit bmode  = 1'b0;
    bit prbs_q[$];

    ber_monitor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sym_I      (sym_I),
        .sym_Q      (sym_Q),
        .sym_valid  (sym_valid),
        .clear      (clear),
`ifdef BER_ERR_INJECT_EN
        .inject_err (inject_err),
`endif
        .locked     (locked),
        .state      (state),
        .err_total  (err_total),
        .bit_total  (bit_total),
        .win_errors (win_errors),
        .win_done   (win_done)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Count win_done pulses shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (win_done === 1'b1) wd_cnt++;
    end

    // Reference PRBS-9: b[n] = b[n-5] ^ b[n-9].
    function automatic bit next_bit();
        bit b;
        b = prbs_q[prbs_q.size() - 5] ^ prbs_q[prbs_q.size() - 9];
        prbs_q.push_back(b);
        void'(prbs_q.pop_front());
        return b;
    endfunction

    // Nominal levels, or slicer-boundary levels when edge_m is set.
    function automatic logic [11:0] lvl(input logic [1:0] b, input bit edge_m, input int k);
        logic [11:0] v;
        if (!edge_m) begin
            case (b)
                2'b00:   v = -12'sd768;
                2'b01:   v = -12'sd256;
                2'b11:   v = 12'sd256;
                default: v = 12'sd768;
            endcase
        end else begin
            case (b)
                2'b00:   v = k[0] ? -12'sd513 : -12'sd2048;
                2'b01:   v = k[0] ? -12'sd512 : -12'sd1;
                2'b11:   v = k[0] ? 12'sd0 : 12'sd511;
                default: v = k[0] ? 12'sd512 : 12'sd2047;
            endcase
        end
        return v;
    endfunction

    task automatic send(input logic [3:0] flip, input logic clr);
        logic [3:0] b;
        for (int i = 3; i >= 0; i--) b[i] = next_bit();
        b = b ^ flip;
        @(negedge clk);
        sym_I = lvl(b[3:2], bmode, alt);
        sym_Q = lvl(b[1:0], bmode, alt + 1);
        alt++;
        sym_valid = 1'b1;
        clear = clr;
    endtask

    task automatic idle();
        @(negedge clk);
        sym_valid = 1'b0;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sym_valid = 1'b0;
        clear = 1'b0;
        sym_I = '0;
        sym_Q = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b want 00", state); end
        n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
        n_cmp++; if (err_total !== 32'd0) begin n_fail++; $display("FAIL reset_err_total: got %h want 0", err_total); end
        n_cmp++; if (bit_total !== 32'd0) begin n_fail++; $display("FAIL reset_bit_total: got %h want 0", bit_total); end
        n_cmp++; if (win_errors !== 16'd0) begin n_fail++; $display("FAIL reset_win_errors: got %h want 0", win_errors); end
        n_cmp++; if (win_done !== 1'b0) begin n_fail++; $display("FAIL reset_win_done: got %b want 0", win_done); end
        rst_n = 1'b1;
    endtask

    task automatic test_lock();
        wd0 = wd_cnt;
        repeat (3) send(4'b0, 1'b0);
        idle();
        n_cmp++; if (state !== 2'b01) begin n_fail++; $display("FAIL lock_verify_at3: got %b want 01", state); end
        repeat (15) send(4'b0, 1'b0);
        idle();
        n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early18: got %b want 0", locked); end
        send(4'b0, 1'b0);
        idle();
        n_cmp++; if (state !== 2'b10) begin n_fail++; $display("FAIL lock_state19: got %b want 10", state); end
        n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_locked19: got %b want 1", locked); end
        n_cmp++; if (bit_total !== 32'd0) begin n_fail++; $display("FAIL lock_bits19: got %0d want 0", bit_total); end
        repeat (1023) send(4'b0, 1'b0);
        idle();
        n_cmp++; if (wd_cnt - wd0 !== 0) begin n_fail++; $display("FAIL lock_early_win: got %0d want 0", wd_cnt - wd0); end
        n_cmp++; if (bit_total !== 32'd4092) begin n_fail++; $display("FAIL lock_bits1023: got %0d want 4092", bit_total); end
        send(4'b0, 1'b0);
        idle();
        n_cmp++; if (win_done !== 1'b1) begin n_fail++; $display("FAIL lock_win_done: got %b want 1", win_done); end
        n_cmp++; if (wd_cnt - wd0 !== 1) begin n_fail++; $display("FAIL lock_win_count: got %0d want 1", wd_cnt - wd0); end
        n_cmp++; if (win_errors !== 16'd0) begin n_fail++; $display("FAIL lock_win_errors: got %0d want 0", win_errors); end
        n_cmp++; if (bit_total !== 32'd4096) begin n_fail++; $display("FAIL lock_bit_total: got %0d want 4096", bit_total); end
        n_cmp++; if (err_total !== 32'd0) begin n_fail++; $display("FAIL lock_err_total: got %0d want 0", err_total); end
    endtask

    task automatic test_idle_hold();
        repeat (5) @(negedge clk);
        n_cmp++; if (bit_total !== 32'd4096) begin n_fail++; $display("FAIL idle_bits: got %0d want 4096", bit_total); end
        n_cmp++; if (state !== 2'b10) begin n_fail++; $display("FAIL idle_state: got %b want 10", state); end
        n_cmp++; if (win_done !== 1'b0) begin n_fail++; $display("FAIL idle_win_done: got %b want 0", win_done); end
    endtask

    task automatic test_window_errors();
        wd0 = wd_cnt;
        for (int i = 0; i < 1024; i++)
            send(((i % 100 == 7) && (i < 1000)) ? 4'b0001 : 4'b0000, 1'b0);
        idle();
        n_cmp++; if (win_errors !== 16'd10) begin n_fail++; $display("FAIL win10_win_errors: got %0d want 10", win_errors); end
        n_cmp++; if (err_total !== 32'd10) begin n_fail++; $display("FAIL win10_err_total: got %0d want 10", err_total); end
        n_cmp++; if (bit_total !== 32'd8192) begin n_fail++; $display("FAIL win10_bit_total: got %0d want 8192", bit_total); end
        n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL win10_locked: got %b want 1", locked); end
        n_cmp++; if (wd_cnt - wd0 !== 1) begin n_fail++; $display("FAIL win10_win_count: got %0d want 1", wd_cnt - wd0); end
    endtask

    task automatic test_loss_relock();
        wd0 = wd_cnt;
        repeat (1023) send(4'b0001, 1'b0);
        idle();
        n_cmp++; if (state !== 2'b10) begin n_fail++; $display("FAIL loss_hold_state: got %b want 10", state); end
        send(4'b0001, 1'b0);
        idle();
        n_cmp++; if (state !== 2'b00) begin n_fail++; $display("FAIL loss_state: got %b want 00", state); end
        n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL loss_locked: got %b want 0", locked); end
        n_cmp++; if (win_done !== 1'b1) begin n_fail++; $display("FAIL loss_win_done: got %b want 1", win_done); end
        n_cmp++; if (win_errors !== 16'd1024) begin n_fail++; $display("FAIL loss_win_errors: got %0d want 1024", win_errors); end
        n_cmp++; if (err_total !== 32'd1034) begin n_fail++; $display("FAIL loss_err_total: got %0d want 1034", err_total); end
        n_cmp++; if (bit_total !== 32'd12288) begin n_fail++; $display("FAIL loss_bit_total: got %0d want 12288", bit_total); end
        repeat (18) send(4'b0, 1'b0);
        idle();
        n_cmp++; if (state !== 2'b01) begin n_fail++; $display("FAIL relock_verify18: got %b want 01", state); end
        send(4'b0, 1'b0);
        idle();
        n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL relock_locked19: got %b want 1", locked); end
        n_cmp++; if (wd_cnt - wd0 !== 1) begin n_fail++; $display("FAIL relock_win_count: got %0d want 1", wd_cnt - wd0); end
    endtask

    task automatic test_saturation_clear();
        force dut.err_total_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.err_total_q;
        n_cmp++; if (err_total !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sat_preset: got %h want fffffffe", err_total); end
        send(4'b1001, 1'b0);
        idle();
        n_cmp++; if (err_total !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_err_total: got %h want ffffffff", err_total); end
        n_cmp++; if (bit_total !== 32'd12292) begin n_fail++; $display("FAIL sat_bit_total: got %0d want 12292", bit_total); end
        send(4'b0110, 1'b0);
        idle();
        n_cmp++; if (err_total !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_nowrap: got %h want ffffffff", err_total); end
        send(4'b1111, 1'b1);
        idle();
        n_cmp++; if (err_total !== 32'd0) begin n_fail++; $display("FAIL clr_err_total: got %h want 0", err_total); end
        n_cmp++; if (bit_total !== 32'd0) begin n_fail++; $display("FAIL clr_bit_total: got %0d want 0", bit_total); end
        n_cmp++; if (win_errors !== 16'd0) begin n_fail++; $display("FAIL clr_win_errors: got %0d want 0", win_errors); end
        n_cmp++; if (state !== 2'b10) begin n_fail++; $display("FAIL clr_state: got %b want 10", state); end
        send(4'b0, 1'b0);
        idle();
        n_cmp++; if (err_total !== 32'd0) begin n_fail++; $display("FAIL clr_lfsr_adv: got %0d want 0", err_total); end
        n_cmp++; if (bit_total !== 32'd4) begin n_fail++; $display("FAIL clr_count_resume: got %0d want 4", bit_total); end
    endtask

    task automatic test_reset_mid_window();
        repeat (499) send(4'b0, 1'b0);
        idle();
        wd0 = wd_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++; if (state !== 2'b00) begin n_fail++; $display("FAIL midrst_state: got %b want 00", state); end
        n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL midrst_locked: got %b want 0", locked); end
        n_cmp++; if (bit_total !== 32'd0) begin n_fail++; $display("FAIL midrst_bit_total: got %0d want 0", bit_total); end
        n_cmp++; if (err_total !== 32'd0) begin n_fail++; $display("FAIL midrst_err_total: got %0d want 0", err_total); end
        n_cmp++; if (win_done !== 1'b0) begin n_fail++; $display("FAIL midrst_win_done: got %b want 0", win_done); end
        n_cmp++; if (wd_cnt - wd0 !== 0) begin n_fail++; $display("FAIL midrst_win_count: got %0d want 0", wd_cnt - wd0); end
    endtask

    task automatic test_slicer_bounds();
        bmode = 1'b1;
        wd0 = wd_cnt;
        repeat (19) send(4'b0, 1'b0);
        idle();
        n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL edge_locked: got %b want 1", locked); end
        repeat (1023) send(4'b0, 1'b0);
        idle();
        n_cmp++; if (wd_cnt - wd0 !== 0) begin n_fail++; $display("FAIL edge_early_win: got %0d want 0", wd_cnt - wd0); end
        n_cmp++; if (err_total !== 32'd0) begin n_fail++; $display("FAIL edge_err_mid: got %0d want 0", err_total); end
        send(4'b0, 1'b0);
        idle();
        n_cmp++; if (win_done !== 1'b1) begin n_fail++; $display("FAIL edge_win_done: got %b want 1", win_done); end
        n_cmp++; if (win_errors !== 16'd0) begin n_fail++; $display("FAIL edge_win_errors: got %0d want 0", win_errors); end
        n_cmp++; if (err_total !== 32'd0) begin n_fail++; $display("FAIL edge_err_total: got %0d want 0", err_total); end
        n_cmp++; if (bit_total !== 32'd4096) begin n_fail++; $display("FAIL edge_bit_total: got %0d want 4096", bit_total); end
        bmode = 1'b0;
    endtask

`ifdef BER_ERR_INJECT_EN
    task automatic test_inject();
        inject_err = 1'b1;
        send(4'b0, 1'b0);
        idle();
        inject_err = 1'b0;
        n_cmp++; if (err_total !== 32'd1) begin n_fail++; $display("FAIL inject_err_total: got %0d want 1", err_total); end
        n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL inject_locked: got %b want 1", locked); end
    endtask
`endif

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        prbs_q = '{1, 0, 0, 0, 0, 1, 1, 0, 1};
`ifdef BER_ERR_INJECT_EN
        inject_err = 1'b0;
`endif
        test_reset();
        test_lock();
        test_idle_hold();
        test_window_errors();
        test_loss_relock();
        test_saturation_clear();
        test_reset_mid_window();
        test_slicer_bounds();
`ifdef BER_ERR_INJECT_EN
        test_inject();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ber_monitor.md
BER_MONITOR -- requirements
Module: ber_monitor

Interface
REQ-001 Parameter SLICE_THR, default 12'sd512: 16-QAM inner/outer decision threshold magnitude.
REQ-002 Parameter VERIFY_SYMS, default 16: consecutive error-free symbols needed to declare lock.
REQ-003 Parameter WINDOW_SYMS, default 1024: symbols per error-measurement window.
REQ-004 Parameter LOSS_THR, default 64: bit errors in one window that force loss of lock.
REQ-005 clk  in  1: clk_dsp domain clock; single clock, no other clock in the block.
REQ-006 rst_n  in  1: reset, synchronous and active-low.
REQ-007 sym_I, sym_Q  in  12 each: demodulated symbol, sample_t (12-bit two's complement), from rx_top demod_I/demod_Q.
REQ-008 sym_valid  in  1: one-cycle qualifier, one symbol per assertion.
REQ-009 clear  in  1: synchronous counter clear.
REQ-010 locked  out  1: high in LOCKED state.
REQ-011 state  out  2: 00 SEARCH, 01 VERIFY, 10 LOCKED.
REQ-012 err_total, bit_total  out  32 each: cumulative bit errors / compared bits, saturating.
REQ-013 win_errors  out  16: bit errors of last completed window, saturating.
REQ-014 win_done  out  1: one-cycle pulse when win_errors updates.

Function
REQ-015 Slicer per axis: v < -SLICE_THR -> 00; -SLICE_THR <= v < 0 -> 01; 0 <= v < SLICE_THR -> 11; v >= SLICE_THR -> 10; I gives b3b2, Q gives b1b0.
REQ-016 Reference is PRBS-9 (x^9+x^5+1); 9-bit LFSR advanced 4 steps per valid symbol; first generated bit compares with b3, last with b0.
REQ-017 SEARCH: each valid symbol shifts its 4 bits (b3 first) into a 12-bit history; after the 3rd symbol since entry, LFSR loads the newest 9 history bits and state -> VERIFY.
REQ-018 VERIFY: each valid symbol compared with LFSR prediction; any mismatch -> SEARCH with history count reset; VERIFY_SYMS consecutive matches -> LOCKED.
REQ-019 LOCKED: LFSR free-runs (never reloaded from received data); error count per symbol = popcount(rx XOR predicted), 0..4.
REQ-020 In LOCKED only: err_total += popcount, bit_total += 4 per valid symbol; each saturates at 32'hFFFF_FFFF with no wrap.
REQ-021 Window counter counts LOCKED valid symbols; on the WINDOW_SYMS-th: win_errors <= window error sum (saturating at 16'hFFFF), win_done pulses next cycle, window sum and counter restart at 0.
REQ-022 At window end with window sum >= LOSS_THR: state -> SEARCH same cycle as win_done; err_total/bit_total retain values.
REQ-023 Entering LOCKED zeroes window counter and window sum; leaving LOCKED discards the partial window with no win_done.
REQ-024 All outputs registered; counters/state reflect a symbol one cycle after its sym_valid.
REQ-025 clear zeroes err_total, bit_total, win_errors, window sum and window counter; state unchanged; clear concurrent with sym_valid: clear wins, symbol not counted but still advances LFSR/state logic.
REQ-026 sym_valid low: no state, LFSR or counter change.

Reset
REQ-027 rst_n low at a clk edge: state SEARCH, locked 0, all counters, win_errors, win_done, LFSR and history 0; mid-window reset discards the window.

Configuration
REQ-028 Macro BER_ERR_INJECT_EN defined: adds input inject_err (1 bit); when high with sym_valid, received b0 is inverted before comparison in all states.
REQ-029 Macro BER_ERR_INJECT_EN undefined: inject_err port absent; comparison uses slicer output unmodified.

Verification
REQ-030 Clean PRBS-9 16-QAM symbols (levels +/-256, +/-768) -> locked after 3+16=19 symbols; bit_total 4096, err_total 0 after further 1024 symbols; win_done once, win_errors 0.
REQ-031 Locked; inject_err on 10 symbols within one window -> win_errors 10, err_total 10, still locked.
REQ-032 Locked; inject_err on every symbol of a window -> win_errors 1024 >= 64 -> state SEARCH with win_done; relock within 19 symbols after injection stops.
REQ-033 Input exactly -512, 0, +511, +512 on I -> sliced b3b2 = 01, 11, 11, 10.
REQ-034 Force err_total to 32'hFFFF_FFFE, 2 erroneous bits -> err_total holds 32'hFFFF_FFFF; clear with sym_valid same cycle -> all counters 0.
REQ-035 rst_n low for 1 cycle at window symbol 500 -> state SEARCH, counters 0, no win_done.
